// File: rtl/sample_i2s_tx_pkg.sv
// Shared audio sample definitions for the adsr -> i2s path and the future mixer.
package sample_i2s_tx_pkg;

   localparam int SAMPLE_WIDTH = 16;

   typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

   // Word-select level for each I2S slot
   localparam logic SLOT_LEFT  = 1'b0;
   localparam logic SLOT_RIGHT = 1'b1;

   // Word-select level for a given frame bit position; ws leads data by one bclk,
   // so the left level spans positions width-1 .. 2*width-2.
   function automatic logic ws_for_count(input int unsigned cnt, input int unsigned width);
      if (cnt >= width - 1 && cnt <= 2 * width - 2) begin
         return SLOT_LEFT;
      end
      return SLOT_RIGHT;
   endfunction

endpackage

// File: rtl/sample_i2s_tx_fifo.sv
// Synchronous sample FIFO; a push to a full FIFO is accepted when a pop happens in the same clk.
module sample_fifo
   import sample_i2s_tx_pkg::*;
#(
   parameter int WIDTH = SAMPLE_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (level_q == LVL_W'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // Accept/pop qualification and next pointer/level values
   always_comb begin
      do_pop   = pop_i && !empty_o;
      do_push  = push_i && (!full_o || do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_d  = level_q;
      if (do_push && !do_pop) begin
         level_d = level_q + 1'b1;
      end else if (!do_push && do_pop) begin
         level_d = level_q - 1'b1;
      end
   end

   // Pointer and level registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage; contents are don't-care after reset since pointers are cleared
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/sample_i2s_tx.sv
// Mono sample sink: buffers strobed samples and serialises each onto both slots of an I2S frame.
module sample_i2s_tx
   import sample_i2s_tx_pkg::*;
#(
   parameter int WIDTH      = SAMPLE_WIDTH,
   parameter int FIFO_DEPTH = 4,
   parameter int BCLK_DIV   = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [WIDTH-1:0]            sample_in,
   input  logic                        in_ready,
   output logic                        bclk,
   output logic                        lrclk,
   output logic                        sdata,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        overflow,
   output logic                        underrun
);

   localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam int CNT_W = $clog2(2 * WIDTH);

   logic [DIV_W-1:0] div_q, div_d;
   logic             bclk_q, bclk_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             started_q, started_d;
   logic [WIDTH-1:0] samp_q, samp_d;
   logic             lrclk_q, lrclk_d;
   logic             sdata_q, sdata_d;
   logic             overflow_q, overflow_d;
   logic             underrun_q, underrun_d;

   logic             div_tc;
   logic             fall_evt;
   logic             frame_start;
   logic             pop;
   logic [CNT_W-1:0] slot_pos;
   logic [WIDTH-1:0] samp_shifted;

   logic [WIDTH-1:0] fifo_head;
   logic             fifo_full;
   logic             fifo_empty;

   sample_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (in_ready),
      .pop_i   (frame_start),
      .wdata_i (sample_in),
      .rdata_o (fifo_head),
      .level_o (fifo_level),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Bit-clock divider, frame bit position and per-bit output selection
   always_comb begin
      div_tc       = (div_q == DIV_W'(BCLK_DIV - 1));
      fall_evt     = div_tc && bclk_q;
      div_d        = div_tc ? '0 : div_q + 1'b1;
      bclk_d       = div_tc ? ~bclk_q : bclk_q;
      cnt_d        = cnt_q;
      started_d    = started_q;
      samp_d       = samp_q;
      lrclk_d      = lrclk_q;
      sdata_d      = sdata_q;
      frame_start  = 1'b0;
      slot_pos     = '0;
      samp_shifted = '0;
      if (fall_evt) begin
         // The very first falling edge after reset opens frame 0 without advancing the count
         if (!started_q) begin
            started_d   = 1'b1;
            cnt_d       = '0;
            frame_start = 1'b1;
         end else begin
            cnt_d       = (cnt_q == CNT_W'(2 * WIDTH - 1)) ? '0 : cnt_q + 1'b1;
            frame_start = (cnt_d == '0);
         end
         if (frame_start) begin
            samp_d = fifo_empty ? '0 : fifo_head;
         end
         lrclk_d      = ws_for_count(32'(cnt_d), WIDTH);
         slot_pos     = (cnt_d >= CNT_W'(WIDTH)) ? cnt_d - CNT_W'(WIDTH) : cnt_d;
         samp_shifted = samp_d << slot_pos;
         sdata_d      = samp_shifted[WIDTH-1];
      end
      pop        = frame_start && !fifo_empty;
      underrun_d = frame_start && fifo_empty;
      overflow_d = overflow_q | (in_ready && fifo_full && !pop);
   end

   // Serialiser and status registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         div_q      <= '0;
         bclk_q     <= 1'b0;
         cnt_q      <= '0;
         started_q  <= 1'b0;
         samp_q     <= '0;
         lrclk_q    <= SLOT_RIGHT;
         sdata_q    <= 1'b0;
         overflow_q <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         div_q      <= div_d;
         bclk_q     <= bclk_d;
         cnt_q      <= cnt_d;
         started_q  <= started_d;
         samp_q     <= samp_d;
         lrclk_q    <= lrclk_d;
         sdata_q    <= sdata_d;
         overflow_q <= overflow_d;
         underrun_q <= underrun_d;
      end
   end

   assign bclk     = bclk_q;
   assign lrclk    = lrclk_q;
   assign sdata    = sdata_q;
   assign overflow = overflow_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_sample_i2s_tx.sv
// Bench for sample_i2s_tx: per-clock reference model, stream table and decoded-frame sequences.
module tb_sample_i2s_tx;

   localparam int W  = 16;
   localparam int D  = 4;
   localparam int B  = 4;
   localparam int LW = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          in_ready = 1'b0;
   logic [W-1:0]  sample_in = '0;
   logic          bclk, lrclk, sdata, overflow, underrun;
   logic [LW-1:0] fifo_level;

   sample_i2s_tx #(.WIDTH(W), .FIFO_DEPTH(D), .BCLK_DIV(B)) dut (
      .clk        (clk),
      .reset      (reset),
      .sample_in  (sample_in),
      .in_ready   (in_ready),
      .bclk       (bclk),
      .lrclk      (lrclk),
      .sdata      (sdata),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .underrun   (underrun)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // reference model state: clocks since reset, queue of buffered samples, sample in flight
   int           n = 0;
   logic [W-1:0] q[$];
   logic [W-1:0] held = '0;
   logic         m_ovf = 1'b0, e_bclk = 1'b0, e_lr = 1'b1, e_sd = 1'b0, e_ur = 1'b0;

   logic rx_bits[$];
   logic rx_ws[$];
   int   ur_seen = 0;
   logic prev_bclk = 1'b0;

   typedef struct {
      int   period;
      int   n_strobes;
      logic exp_ovf;
      int   exp_ur;
   } stream_vec_t;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         if (fails <= 40) $display("FAIL %s: actual %0h required %0h", name, got, exp);
      end
   endtask

   task automatic model_step();
      int k, cnt;
      if (!reset) begin
         n = 0; q.delete(); m_ovf = 1'b0; held = '0;
         e_bclk = 1'b0; e_lr = 1'b1; e_sd = 1'b0; e_ur = 1'b0;
      end else begin
         n++;
         e_ur = 1'b0;
         if (n % B == 0) e_bclk = ((n / B) % 2) == 1;
         if (n % (2 * B) == 0) begin
            k   = n / (2 * B);
            cnt = (k - 1) % (2 * W);
            if (cnt == 0) begin
               if (q.size() > 0) held = q.pop_front();
               else begin
                  held = '0;
                  e_ur = 1'b1;
               end
            end
            e_lr = !(cnt >= W - 1 && cnt <= 2 * W - 2);
            e_sd = held[W - 1 - (cnt % W)];
         end
         if (in_ready) begin
            if (q.size() < D) q.push_back(sample_in);
            else m_ovf = 1'b1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check($sformatf("outputs n=%0d", n), {bclk, lrclk, sdata, fifo_level, overflow, underrun},
            {e_bclk, e_lr, e_sd, LW'(q.size()), m_ovf, e_ur});
      if (bclk && !prev_bclk && n > 2 * B) begin
         rx_bits.push_back(sdata);
         rx_ws.push_back(lrclk);
      end
      if (underrun) ur_seen++;
      prev_bclk = bclk;
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b0;
      in_ready = 1'b0;
      repeat (cycles) begin
         tick();
         check("reset_state", {bclk, lrclk, sdata, fifo_level, overflow, underrun}, 8'b0100_0000);
      end
      reset = 1'b1;
      rx_bits.delete();
      rx_ws.delete();
      ur_seen = 0;
      prev_bclk = 1'b0;
   endtask

   task automatic run(input int len, input int period, input int nstrobes);
      for (int i = 0; i < len; i++) begin
         in_ready  = (i % period == 0) && (i / period < nstrobes);
         sample_in = W'($urandom);
         tick();
      end
      in_ready = 1'b0;
   endtask

   function automatic logic [W-1:0] word_at(input int s);
      logic [W-1:0] w;
      w = 'x;
      if (s + W <= rx_bits.size())
         for (int i = 0; i < W; i++) w[W-1-i] = rx_bits[s+i];
      return w;
   endfunction

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      stream_vec_t vecs[5];
      logic [W-1:0] s[5];
      logic [31:0] ws_got, ws_exp;
      int k;

      vecs[0] = '{10, 200, 1'b1, 0};
      vecs[1] = '{256, 8, 1'b0, 0};
      vecs[2] = '{512, 4, 1'b0, 4};
      vecs[3] = '{1, 5, 1'b1, 0};
      vecs[4] = '{3, 40, 1'b1, 0};

      // mid-frame reset, then first bclk rise timing
      do_reset(2);
      run(300, 37, 20);
      do_reset(10);
      k = 0;
      do begin
         tick();
         k++;
      end while (!bclk && k < 20);
      check("first_bclk_rise_clks", k, B);
      run(300, 1, 0);

      // single full-scale sample, then an empty frame
      do_reset(2);
      in_ready = 1'b1; sample_in = 16'h7FFF;
      tick();
      in_ready = 1'b0;
      repeat (518) tick();
      check("single_left", word_at(0), 16'h7FFF);
      check("single_right", word_at(W), 16'h7FFF);
      check("single_next_left", word_at(2 * W), 16'h0000);
      check("single_next_right", word_at(3 * W), 16'h0000);
      check("single_underruns", ur_seen, 1);

      // pattern sample with word-select alignment
      do_reset(2);
      in_ready = 1'b1; sample_in = 16'hA5C3;
      tick();
      in_ready = 1'b0;
      repeat (518) tick();
      check("pattern_left", word_at(0), 16'hA5C3);
      check("pattern_right", word_at(W), 16'hA5C3);
      ws_got = 'x;
      for (int i = 0; i < 32 && i < rx_ws.size(); i++) ws_got[i] = rx_ws[i];
      ws_exp = 32'h8000_7FFF;
      check("pattern_lrclk", ws_got, ws_exp);

      // overflow: five back-to-back strobes before the first pop
      do_reset(2);
      for (int i = 0; i < 5; i++) begin
         s[i] = W'($urandom) | 16'h0101;
         in_ready = 1'b1; sample_in = s[i];
         tick();
      end
      in_ready = 1'b0;
      check("ovf_level", fifo_level, 3'd4);
      check("ovf_flag", overflow, 1'b1);
      repeat (1285) tick();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ovf_frame%0d_left", i), word_at(2 * W * i), s[i]);
         check($sformatf("ovf_frame%0d_right", i), word_at(2 * W * i + W), s[i]);
      end
      check("ovf_fifth_dropped", word_at(8 * W), 16'h0000);

      // collision: strobe on the exact pop clock of a full FIFO
      do_reset(2);
      for (int i = 0; i < 4; i++) begin
         in_ready = 1'b1; sample_in = W'($urandom);
         tick();
      end
      in_ready = 1'b0;
      repeat (3) tick();
      check("coll_full_before", fifo_level, 3'd4);
      in_ready = 1'b1; sample_in = 16'h1234;
      tick();
      in_ready = 1'b0;
      check("coll_level", fifo_level, 3'd4);
      check("coll_no_ovf", overflow, 1'b0);
      run(40, 1, 0);

      // stream table
      for (int v = 0; v < 5; v++) begin
         do_reset(2);
         run(vecs[v].period * vecs[v].n_strobes, vecs[v].period, vecs[v].n_strobes);
         check($sformatf("stream%0d_overflow", v), overflow, vecs[v].exp_ovf);
         check($sformatf("stream%0d_underruns", v), ur_seen, vecs[v].exp_ur);
      end

      // random strobes against the model
      do_reset(3);
      for (int i = 0; i < 3000; i++) begin
         in_ready  = ($urandom_range(0, 299) < 3);
         sample_in = W'($urandom);
         tick();
      end
      in_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
